rece_ram_reader: RTL and testbench

- Downstream consumer of the receive RAM. Tracks the RAM's write-position counter against its own read pointer and fetches each newly written byte through the RAM's registered read port.
- Presents each byte on a valid/ready stream to the command/host-side logic.
- The write counter comes from the clk_BPS_i domain and is resynchronised here into clk_i.

---
 rtl/rece_ram_reader_if.sv | 28 ++
 rtl/rece_ram_reader.sv | 152 +++++++++++++++
 tb/tb_rece_ram_reader.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/rece_ram_reader_if.sv
// Bundles the receive-RAM port and the downstream byte stream of rece_ram_reader.
// The master modport is the reader's view; slave is the RAM/consumer side.
interface rece_ram_reader_if;
    logic [7:0] rece_addr_counter;
    logic [7:0] rece_data;
    logic [7:0] rece_addr;
    logic [7:0] data;
    logic       valid;
    logic       ready;

    modport master (
        input  rece_addr_counter,
        input  rece_data,
        input  ready,
        output rece_addr,
        output data,
        output valid
    );

    modport slave (
        output rece_addr_counter,
        output rece_data,
        output ready,
        input  rece_addr,
        input  data,
        input  valid
    );
endinterface

// File: rtl/rece_ram_reader.sv
// Receive-RAM reader: resynchronises the write counter, fetches each new byte, streams it out.
// Optional macro RECE_READER_STAT_EN adds a saturating 16-bit accepted-byte counter (stat_count_o).
//
// state | meaning
// IDLE  | nothing in flight; start a fetch when bytes are pending
// REQ   | RAM samples rece_addr this edge
// CAPT  | RAM data is valid; capture it into data_o
// HOLD  | data_o presented with valid_o, waiting for ready
module rece_ram_reader #(
    parameter int unsigned RING_SIZE = 255
) (
    input  logic                clk_i,
    input  logic                rst_i,
    rece_ram_reader_if.master   bus,
    input  logic                flush_i,
    output logic [7:0]          level_o,
    output logic                overrun_o
`ifdef RECE_READER_STAT_EN
    ,
    output logic [15:0]         stat_count_o
`endif
);

    localparam logic [8:0] RING9 = 9'(RING_SIZE);
    localparam logic [7:0] LAST  = 8'(RING_SIZE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        CAPT = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t     state_q;
    logic [7:0] s1_q, s2_q, s3_q;
    logic [7:0] wr_ptr_q, wr_ptr_d;
    logic [7:0] rd_ptr_q, rd_ptr_inc;
    logic [7:0] rece_addr_q;
    logic [7:0] data_q;
    logic       valid_q;
    logic [7:0] level_q, level_d;
    logic       overrun_q;
    logic       accept;

    // Load wr_ptr with the value s2 takes this edge when s3 will match it,
    // i.e. two consecutive identical samples; wr_ptr thus moves on edge 3.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        if (s1_q == s2_q) begin
            wr_ptr_d = s1_q;
        end
    end

    always_comb begin
        level_d = 8'd0;
        if (wr_ptr_q >= rd_ptr_q) begin
            level_d = 8'({1'b0, wr_ptr_q} - {1'b0, rd_ptr_q});
        end else begin
            level_d = 8'({1'b0, wr_ptr_q} + RING9 - {1'b0, rd_ptr_q});
        end
    end

    assign rd_ptr_inc = (rd_ptr_q == LAST) ? 8'd0 : rd_ptr_q + 8'd1;
    assign accept     = (state_q == HOLD) && bus.ready && !flush_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_q     <= 8'd0;
            s2_q     <= 8'd0;
            s3_q     <= 8'd0;
            wr_ptr_q <= 8'd0;
            level_q  <= 8'd0;
        end else begin
            s1_q     <= bus.rece_addr_counter;
            s2_q     <= s1_q;
            s3_q     <= s2_q;
            wr_ptr_q <= wr_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            rd_ptr_q    <= 8'd0;
            rece_addr_q <= 8'd0;
            data_q      <= 8'd0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
        end else if (flush_i) begin
            // A byte on offer during flush is dropped, never delivered.
            state_q   <= IDLE;
            rd_ptr_q  <= wr_ptr_q;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (level_d == LAST) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (wr_ptr_q != rd_ptr_q) begin
                        rece_addr_q <= rd_ptr_q;
                        state_q     <= REQ;
                    end
                end
                REQ: begin
                    state_q <= CAPT;
                end
                CAPT: begin
                    data_q  <= bus.rece_data;
                    valid_q <= 1'b1;
                    state_q <= HOLD;
                end
                HOLD: begin
                    if (bus.ready) begin
                        valid_q  <= 1'b0;
                        rd_ptr_q <= rd_ptr_inc;
                        state_q  <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef RECE_READER_STAT_EN
    logic [15:0] stat_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stat_q <= 16'd0;
        end else if (accept && (stat_q != 16'hFFFF)) begin
            stat_q <= stat_q + 16'd1;
        end
    end

    assign stat_count_o = stat_q;
`else
    logic unused_accept;
    assign unused_accept = accept;
`endif

    assign bus.rece_addr = rece_addr_q;
    assign bus.data      = data_q;
    assign bus.valid     = valid_q;
    assign level_o       = level_q;
    assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_rece_ram_reader.sv
// Self-checking bench for rece_ram_reader: RAM model, scoreboard of expected bytes,
// directed checks on latency, backpressure, wrap, overrun, flush, sync glitch and async reset.
module tb_rece_ram_reader;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       flush = 1'b0;
    logic [7:0] level;
    logic       overrun;
`ifdef RECE_READER_STAT_EN
    logic [15:0] stat;
`endif

    logic [7:0] mem [256];
    logic [7:0] sb [$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         n_acc   = 0;
    logic [7:0] lvl_max;

    rece_ram_reader_if bus ();

    always #5 clk = ~clk;

    rece_ram_reader #(.RING_SIZE(255)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .bus       (bus),
        .flush_i   (flush),
        .level_o   (level),
        .overrun_o (overrun)
`ifdef RECE_READER_STAT_EN
        ,
        .stat_count_o (stat)
`endif
    );

    // Registered-read RAM: data follows the sampled address by one edge.
    always @(posedge clk) bus.rece_data <= mem[bus.rece_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_drain(input int max);
        int i = 0;
        while (sb.size() != 0 && i < max) begin
            step(1);
            i++;
        end
        chk("drain", sb.size(), 0);
    endtask

    task automatic chk_stat();
`ifdef RECE_READER_STAT_EN
        chk("stat", stat, n_acc);
`endif
    endtask

    always @(negedge clk) begin
        if (!rst && bus.valid && bus.ready && !flush) begin
            chk("sb_nonempty", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) chk("sb_data", bus.data, sb.pop_front());
            n_acc++;
        end
    end

    initial begin
        bus.rece_addr_counter = 8'd0;
        bus.ready = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'd0;
        #1 rst = 1'b1;
        #2;
        chk("rst_addr", bus.rece_addr, 0);
        chk("rst_data", bus.data, 0);
        chk("rst_valid", bus.valid, 0);
        chk("rst_level", level, 0);
        chk("rst_overrun", overrun, 0);
        chk_stat();
        step(2);
        rst = 1'b0;
        step(1);

        // single byte, latency
        mem[0] = 8'hA5;
        sb.push_back(8'hA5);
        bus.ready = 1'b1;
        bus.rece_addr_counter = 8'd1;
        step(4);
        chk("single_level1", level, 1);
        chk("single_valid_e4", bus.valid, 0);
        step(1);
        chk("single_valid_e5", bus.valid, 0);
        chk("single_addr", bus.rece_addr, 0);
        step(1);
        chk("single_valid_e6", bus.valid, 1);
        chk("single_data", bus.data, 8'hA5);
        step(1);
        chk("single_pulse", bus.valid, 0);
        step(1);
        chk("single_level0", level, 0);

        // backpressure
        bus.ready = 1'b0;
        mem[1] = 8'h11; mem[2] = 8'h22; mem[3] = 8'h33;
        sb.push_back(8'h11); sb.push_back(8'h22); sb.push_back(8'h33);
        bus.rece_addr_counter = 8'd4;
        step(20);
        chk("bp_valid", bus.valid, 1);
        chk("bp_data", bus.data, 8'h11);
        chk("bp_level", level, 3);
        bus.ready = 1'b1;
        wait_drain(40);
        step(4);
        chk("bp_valid_end", bus.valid, 0);
        chk("bp_level_end", level, 0);
        chk_stat();

        // wrap: align rd=wr=253 via flush, then cross the ring end
        bus.ready = 1'b0;
        bus.rece_addr_counter = 8'd253;
        step(5);
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        step(2);
        chk("wrap_level0", level, 0);
        chk("wrap_valid0", bus.valid, 0);
        mem[253] = 8'hA0; mem[254] = 8'hA1; mem[0] = 8'hA2; mem[1] = 8'hA3;
        sb.push_back(8'hA0); sb.push_back(8'hA1); sb.push_back(8'hA2); sb.push_back(8'hA3);
        bus.rece_addr_counter = 8'd254;
        step(4);
        chk("wrap_level1", level, 1);
        bus.rece_addr_counter = 8'd0;
        step(4);
        bus.rece_addr_counter = 8'd1;
        step(4);
        chk("wrap_level3", level, 3);
        chk("wrap_hold_data", bus.data, 8'hA0);
        bus.rece_addr_counter = 8'd2;
        step(4);
        chk("wrap_level4", level, 4);
        bus.ready = 1'b1;
        wait_drain(60);
        step(4);
        chk("wrap_level_end", level, 0);
        chk("wrap_last_addr", bus.rece_addr, 1);
        chk("wrap_valid_end", bus.valid, 0);

        // overrun: wr runs RING_SIZE-1 ahead of rd (rd=2, wr=1)
        bus.ready = 1'b0;
        chk("ovr_clear", overrun, 0);
        bus.rece_addr_counter = 8'd1;
        step(6);
        chk("ovr_level", level, 8'hFE);
        chk("ovr_set", overrun, 1);
        chk("ovr_valid", bus.valid, 1);
        bus.ready = 1'b1;
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        bus.ready = 1'b0;
        chk("flush_valid", bus.valid, 0);
        chk("flush_overrun", overrun, 0);
        step(1);
        chk("flush_level", level, 0);
        chk_stat();

        // sync glitch: 7F -> FF (one clock) -> 80
        bus.rece_addr_counter = 8'h7F;
        step(5);
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        step(2);
        chk("glitch_base", level, 0);
        mem[8'h7F] = 8'h5A;
        sb.push_back(8'h5A);
        lvl_max = 8'd0;
        bus.rece_addr_counter = 8'hFF;
        step(1);
        bus.rece_addr_counter = 8'h80;
        repeat (10) begin
            step(1);
            if (level > lvl_max) lvl_max = level;
        end
        chk("glitch_max", lvl_max, 1);
        chk("glitch_overrun", overrun, 0);
        bus.ready = 1'b1;
        wait_drain(20);
        step(2);
        bus.ready = 1'b0;
        chk_stat();

        // async reset while holding a byte
        mem[8'h80] = 8'h77;
        bus.rece_addr_counter = 8'h81;
        step(8);
        chk("hold_valid", bus.valid, 1);
        chk("hold_data", bus.data, 8'h77);
        chk("sb_final", sb.size(), 0);
        #1 rst = 1'b1;
        #1;
        chk("arst_valid", bus.valid, 0);
        chk("arst_data", bus.data, 0);
        chk("arst_addr", bus.rece_addr, 0);
        chk("arst_level", level, 0);
        chk("arst_overrun", overrun, 0);
`ifdef RECE_READER_STAT_EN
        chk("arst_stat", stat, 0);
`endif
        step(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
